// File: rtl/imem_loader_if.sv
// Byte-stream and IMEM write-port bundle for imem_loader.
// The slave modport is the loader side; master is the source/IMEM side.
interface imem_loader_if #(
    parameter int INST_WIDTH_LENGTH = 32,
    parameter int MAX_MEM_DEPTH_BIT = 18
);
    logic                         in_valid;
    logic [7:0]                   in_data;
    logic                         in_ready;
    logic                         imem_we;
    logic [MAX_MEM_DEPTH_BIT-2:0] imem_waddr;
    logic [INST_WIDTH_LENGTH-1:0] imem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream IMEM loader: packs bytes little-endian into words and writes them.
// Optional checksum trailer enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int INST_WIDTH_LENGTH = 32,
    parameter int PC_WIDTH_LENGTH   = 32,
    parameter int MAX_MEM_DEPTH_BIT = 18
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PC_WIDTH_LENGTH-1:0]   base_pc,
    input  logic [MAX_MEM_DEPTH_BIT-1:0] word_count,
    input  logic                         abort,
    imem_loader_if.slave                 bus,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK   = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [1:0]                   r_bcnt;
    logic [23:0]                  r_asm;
    logic [MAX_MEM_DEPTH_BIT-2:0] r_addr;
    logic [MAX_MEM_DEPTH_BIT-1:0] r_rem;
    logic [INST_WIDTH_LENGTH-1:0] r_wdata;
    logic                         w_ready;
    logic                         w_accept;
    logic                         w_last_byte;
    logic                         w_unused;

    assign w_unused = ^{base_pc[PC_WIDTH_LENGTH-1:MAX_MEM_DEPTH_BIT+1],
                        base_pc[1:0]};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INST_WIDTH_LENGTH-1:0] r_xsum;
    logic                         r_err;
    assign w_ready = (r_state == COLLECT) || (r_state == CHECK);
    assign busy    = (r_state == COLLECT) || (r_state == WRITE) ||
                     (r_state == CHECK);
    assign err     = r_err;
`else
    assign w_ready = (r_state == COLLECT);
    assign busy    = (r_state == COLLECT) || (r_state == WRITE);
    assign err     = 1'b0;
`endif

    assign w_accept        = bus.in_valid && w_ready;
    assign w_last_byte     = w_accept && (r_bcnt == 2'd3);
    assign bus.in_ready    = w_ready;
    assign bus.imem_we     = (r_state == WRITE);
    assign bus.imem_waddr  = r_addr;
    assign bus.imem_wdata  = r_wdata;
    assign done            = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    if (word_count != '0) w_next = COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    else                  w_next = CHECK;
`else
                    else                  w_next = DONE;
`endif
                end
            end
            COLLECT: begin
                if (abort)            w_next = IDLE;
                else if (w_last_byte) w_next = WRITE;
            end
            WRITE: begin
                if (abort) w_next = IDLE;
                else if (r_rem == MAX_MEM_DEPTH_BIT'(1))
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = DONE;
`endif
                else       w_next = COLLECT;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (abort)            w_next = IDLE;
                else if (w_last_byte) w_next = DONE;
            end
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: bytes 0..2 staged in r_asm, byte 3 completes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_addr  <= '0;
            r_rem   <= '0;
            r_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xsum  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && start && !abort) begin
                r_addr <= base_pc[MAX_MEM_DEPTH_BIT:2];
                r_rem  <= word_count;
                r_bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xsum <= '0;
                r_err  <= 1'b0;
`endif
            end
            if (w_accept && !abort) begin
                r_bcnt <= r_bcnt + 2'd1;
                unique case (r_bcnt)
                    2'd0: r_asm[7:0]   <= bus.in_data;
                    2'd1: r_asm[15:8]  <= bus.in_data;
                    2'd2: r_asm[23:16] <= bus.in_data;
                    2'd3: begin
                        if (r_state == COLLECT)
                            r_wdata <= {bus.in_data, r_asm};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        else
                            r_err <= ({bus.in_data, r_asm} != r_xsum);
`endif
                    end
                    default: r_asm <= r_asm;
                endcase
            end
            if (r_state == WRITE) begin
                r_addr <= r_addr + 1'b1;
                r_rem  <= r_rem - 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xsum <= r_xsum ^ r_wdata;
`endif
            end
            if (abort && r_state != IDLE) r_bcnt <= '0;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_pc = '0;
    logic [17:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy, done, err;
    int          n_err = 0;
    int          n_chk = 0;
    int          n_done = 0;
    int          n_busy = 0;
    int          n_viol = 0;
    int          q0, d0, b0;
    logic [16:0] qa[$];
    logic [31:0] qd[$];

    imem_loader_if bus ();

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc),
        .word_count(word_count), .abort(abort), .bus(bus),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            qa.push_back(bus.imem_waddr);
            qd.push_back(bus.imem_wdata);
        end
        if (bus.imem_we && bus.in_ready) n_viol++;
        if (done) n_done++;
        if (busy) n_busy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_load(input logic [31:0] pc, input logic [17:0] n);
        start = 1'b1; base_pc = pc; word_count = n;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        bus.in_valid = 1'b1; bus.in_data = b;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            step(); t++;
        end
        if (t >= 20) begin
            n_chk++; n_err++;
            $error("FAIL send_timeout observed=%0d expected<20", t);
        end
        step();
        bus.in_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) send(v[8*i +: 8], gap);
    endtask

    task automatic tail(input logic [31:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(cs, 1'b0);
`else
        if (cs === 32'hx) step();
`endif
    endtask

    task automatic chk_wr(input string tag, input int i,
                          input logic [16:0] a, input logic [31:0] d);
        chk({tag, "_addr"}, 32'(qa.size() > i ? qa[i] : 17'h0), 32'(a));
        chk({tag, "_data"}, qa.size() > i ? qd[i] : 32'h0, d);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_we", 32'(bus.imem_we), 0);
        chk("rst_waddr", 32'(bus.imem_waddr), 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Test 1: two words back to back
        q0 = qa.size(); d0 = n_done;
        start_load(32'h0000_0100, 18'd2);
        chk("t1_busy", 32'(busy), 1);
        send_word(32'h0000_0013, 1'b0);
        chk("t1_we0", 32'(bus.imem_we), 1);
        chk("t1_waddr0", 32'(bus.imem_waddr), 32'h40);
        chk("t1_wdata0", bus.imem_wdata, 32'h0000_0013);
        send_word(32'h00B5_05B3, 1'b0);
        chk("t1_we1", 32'(bus.imem_we), 1);
        chk("t1_waddr1", 32'(bus.imem_waddr), 32'h41);
        chk("t1_wdata1", bus.imem_wdata, 32'h00B5_05B3);
        step();
        tail(32'h00B5_05A0);
        chk("t1_done", {30'd0, done, busy}, 32'b10);
        step();
        chk("t1_after", {30'd0, done, busy}, 0);
        chk("t1_nwr", 32'(qa.size() - q0), 2);
        chk("t1_ndone", 32'(n_done - d0), 1);

        // Test 2: valid toggling every other cycle
        q0 = qa.size();
        start_load(32'h0000_0100, 18'd2);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h00B5_05B3, 1'b1);
        tail(32'h00B5_05A0);
        repeat (2) step();
        chk("t2_nwr", 32'(qa.size() - q0), 2);
        chk_wr("t2_w0", q0, 17'h40, 32'h0000_0013);
        chk_wr("t2_w1", q0 + 1, 17'h41, 32'h00B5_05B3);
        chk("t2_viol", 32'(n_viol), 0);

        // Test 3: zero-length load
        q0 = qa.size(); b0 = n_busy;
        start_load(32'h0000_0100, 18'd0);
        tail(32'h0);
        chk("t3_done", {29'd0, done, busy, bus.imem_we}, 32'b100);
        step();
        chk("t3_done_off", 32'(done), 0);
        chk("t3_nwr", 32'(qa.size() - q0), 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        chk("t3_busy_cyc", 32'(n_busy - b0), 0);
`endif

        // Test 4: address wrap and ignored low pc bits
        q0 = qa.size();
        start_load(32'h0007_FFFC, 18'd2);
        send_word(32'h1122_3344, 1'b0);
        send_word(32'hAABB_CCDD, 1'b0);
        step();
        tail(32'hBB99_FF99);
        step();
        chk_wr("t4_w0", q0, 17'h1FFFF, 32'h1122_3344);
        chk_wr("t4_w1", q0 + 1, 17'h00000, 32'hAABB_CCDD);
        q0 = qa.size();
        start_load(32'h0000_0103, 18'd1);
        send_word(32'hDEAD_BEEF, 1'b0);
        step();
        tail(32'hDEAD_BEEF);
        step();
        chk_wr("t4_w2", q0, 17'h40, 32'hDEAD_BEEF);

        // Test 5: abort mid-word, then a fresh load
        q0 = qa.size(); d0 = n_done;
        start_load(32'h0, 18'd3);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_idle", {30'd0, busy, bus.in_ready}, 0);
        repeat (3) step();
        chk("t5_nwr_abort", 32'(qa.size() - q0), 0);
        chk("t5_ndone_abort", 32'(n_done - d0), 0);
        abort = 1'b1;
        start_load(32'h0000_0100, 18'd1);
        abort = 1'b0;
        chk("t5_abort_start", {30'd0, busy, bus.in_ready}, 0);
        start_load(32'h0000_0200, 18'd1);
        send_word(32'h0000_006F, 1'b0);
        chk("t5_waddr", 32'(bus.imem_waddr), 32'h80);
        step();
        tail(32'h0000_006F);
        chk("t5_done", 32'(done), 1);
        step();
        chk("t5_ndone", 32'(n_done - d0), 1);
        chk_wr("t5_w", q0, 17'h80, 32'h0000_006F);
        q0 = qa.size();
        start_load(32'h0000_0300, 18'd2);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready_we", {30'd0, bus.in_ready, bus.imem_we}, 0);
        chk("t5_rst_waddr", 32'(bus.imem_waddr), 0);
        chk("t5_rst_wdata", bus.imem_wdata, 0);
        chk("t5_rst_flags", {29'd0, busy, done, err}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();
        chk("t5_rst_nwr", 32'(qa.size() - q0), 0);
        chk("t5_rst_busy", 32'(busy), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Test 6: checksum pass then fail
        start_load(32'h0000_0100, 18'd2);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h00B5_05B3, 1'b0);
        step();
        send_word(32'h00B5_05A0, 1'b0);
        chk("t6_ok", {30'd0, done, err}, 32'b10);
        step();
        start_load(32'h0000_0100, 18'd2);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h00B5_05B3, 1'b0);
        step();
        send_word(32'h0000_0000, 1'b0);
        chk("t6_bad", {30'd0, done, err}, 32'b11);
        repeat (3) step();
        chk("t6_err_hold", 32'(err), 1);
        start_load(32'h0000_0100, 18'd1);
        chk("t6_err_clr", 32'(err), 0);
        send_word(32'h0000_0013, 1'b0);
        step();
        send_word(32'h0000_0013, 1'b0);
        chk("t6_ok2", {30'd0, done, err}, 32'b10);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
